// File: rtl/spi_pkg.sv
// Shared encodings for the parametrised SPI master: FSM states, {CKP,CPH} modes
// and the chip-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Mode index is {CKP, CPH}.
  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01,
    MODE_2 = 2'b10,
    MODE_3 = 2'b11
  } spi_mode_e;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter that wraps at HALF_DIV-1, SCK toggle while
// shifting, and strobes flagging that a leading/trailing edge happens at this clock edge.
module spi_sck_gen #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic toggle,
  input  logic ckp,
  output logic sck,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    sck_d     = sck_q;
    tick      = run && (cnt_q == CNT_LAST);
    lead_stb  = tick && toggle && (sck_q == ckp);
    trail_stb = tick && toggle && (sck_q != ckp);
    if (!run) begin
      // Parked at the idle level of the mode about to start.
      cnt_d = '0;
      sck_d = ckp;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && toggle) begin
        sck_d = ~sck_q;
      end
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: FSM, TX/RX shift registers, chip-select
// decode and sample-edge bit counter; SCK timing comes from spi_sck_gen.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  DATA_W    = 16,
  parameter int  HALF_DIV  = 4,
  parameter int  NUM_CS    = 1,
  parameter int  LSB_FIRST = 0,
  localparam int CS_W      = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stb,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [NUM_CS-1:0] CS,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for start_stb; SCK follows the live CKP port
  // SETUP | CS asserted, SCK at idle level; CPH=0 already shows first bit
  // SHIFT | SCK toggles every HALF_DIV cycles for DATA_W full periods
  // HOLD  | SCK idle, CS still asserted, MOSI holds the last bit

  localparam int BIT_W = $clog2(DATA_W) + 1;

  spi_state_e        state_q, state_d;
  spi_mode_e         mode_q, mode_d;
  logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic             gen_sck, tick, lead_stb, trail_stb;
  logic             run, toggle, cph;
  logic             sample_stb, drive_stb, shift_done;
  logic [BIT_W-1:0] bit_cnt_inc;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign run    = (state_q != ST_IDLE);
  assign toggle = (state_q == ST_SHIFT);
  assign cph    = mode_q[0];

  spi_sck_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .toggle    (toggle),
    .ckp       (mode_d[1]),
    .sck       (gen_sck),
    .tick      (tick),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_0;
      cs_sel_q   <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      mosi_q     <= 1'b0;
      cs_q       <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cs_sel_q   <= cs_sel_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cs_sel_d   = cs_sel_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = '1;

    sample_stb  = cph ? trail_stb : lead_stb;
    drive_stb   = cph ? lead_stb : trail_stb;
    bit_cnt_inc = bit_cnt_q + BIT_W'(sample_stb);
    // The final trailing edge always closes the transfer, whichever edge samples.
    shift_done  = trail_stb && (bit_cnt_inc == BIT_W'(DATA_W));

    case (state_q)
      ST_IDLE: begin
        if (start_stb) begin
          state_d   = ST_SETUP;
          mode_d    = spi_mode_e'({CKP, CPH});
          cs_sel_d  = cs_sel;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          if (CPH) begin
            tx_sr_d = tx_data;
            mosi_d  = 1'b0;
          end else begin
            tx_sr_d = shift_out(tx_data);
            mosi_d  = first_bit(tx_data);
          end
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sample_stb) begin
          rx_sr_d   = shift_in(rx_sr_q, MISO);
          bit_cnt_d = bit_cnt_inc;
        end
        if (drive_stb && !shift_done) begin
          mosi_d  = first_bit(tx_sr_q);
          tx_sr_d = shift_out(tx_sr_q);
        end
        if (shift_done) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d    = ST_IDLE;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An out-of-range index matches no line, so every CS stays high.
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (cs_sel_d == CS_W'(i)) begin
          cs_d[i] = 1'b0;
        end
      end
    end
  end

  assign SCK      = (state_q == ST_IDLE) ? CKP : gen_sck;
  assign MOSI     = mosi_q;
  assign CS       = cs_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: a 16-bit/3-CS MSB-first master driven from a vector table plus
// hand-written corner sequences, and an 8-bit LSB-first master at HALF_DIV=1.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 16-bit, HALF_DIV=4, NUM_CS=3 (CS_W=2, so index 3 is out of range)
  logic        start_a = 1'b0;
  logic [15:0] tx_a = '0;
  logic [1:0]  sel_a = '0;
  logic        ckp_a = 1'b0, cph_a = 1'b0;
  logic        loop_a = 1'b1, miso_lvl_a = 1'b0;
  logic        miso_a, mosi_a, sck_a, rxv_a, busy_a;
  logic [2:0]  cs_a;
  logic [15:0] rx_a;
  assign miso_a = loop_a ? mosi_a : miso_lvl_a;

  spi_master_param #(
    .DATA_W(16), .HALF_DIV(4), .NUM_CS(3), .LSB_FIRST(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start_stb(start_a), .tx_data(tx_a), .cs_sel(sel_a),
    .CKP(ckp_a), .CPH(cph_a), .MISO(miso_a), .MOSI(mosi_a), .SCK(sck_a), .CS(cs_a),
    .rx_data(rx_a), .rx_valid(rxv_a), .busy(busy_a)
  );

  // 8-bit, HALF_DIV=1, single CS, LSB first, MISO looped to MOSI
  logic       start_b = 1'b0;
  logic [7:0] tx_b = '0;
  logic [0:0] sel_b = '0;
  logic       ckp_b = 1'b0, cph_b = 1'b0;
  logic       miso_b, mosi_b, sck_b, rxv_b, busy_b;
  logic [0:0] cs_b;
  logic [7:0] rx_b;
  assign miso_b = mosi_b;

  spi_master_param #(
    .DATA_W(8), .HALF_DIV(1), .NUM_CS(1), .LSB_FIRST(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start_stb(start_b), .tx_data(tx_b), .cs_sel(sel_b),
    .CKP(ckp_b), .CPH(cph_b), .MISO(miso_b), .MOSI(mosi_b), .SCK(sck_b), .CS(cs_b),
    .rx_data(rx_b), .rx_valid(rxv_b), .busy(busy_b)
  );

  typedef struct {
    logic        ckp;
    logic        cph;
    logic [15:0] tx;
    logic        loop;
    logic        miso_lvl;
    logic [1:0]  sel;
    logic [15:0] exp_rx;
    logic [2:0]  exp_cs;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One transaction on dut_a; inject_cyc >= 1 pulses start with a different word
  // and flipped mode pins at that cycle after accept.
  task automatic run_a(input vec_t v, input int inject_cyc);
    int          cyc, lat, lead;
    logic        prev_sck, seen_lead, cs_ok, busy_ok, pre_ok;
    logic [15:0] mosi_w;
    @(negedge clk);
    tx_a = v.tx; sel_a = v.sel; ckp_a = v.ckp; cph_a = v.cph;
    loop_a = v.loop; miso_lvl_a = v.miso_lvl; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("setup_sck", {31'd0, sck_a}, {31'd0, v.ckp});
    check("setup_mosi", {31'd0, mosi_a}, {31'd0, (v.cph ? 1'b0 : v.tx[15])});
    cyc = 1; lat = -1; lead = 0; prev_sck = v.ckp; seen_lead = 1'b0;
    cs_ok = 1'b1; busy_ok = 1'b1; pre_ok = 1'b1; mosi_w = '0;
    while (cyc < 400) begin
      if (cyc == inject_cyc) begin
        start_a = 1'b1; tx_a = 16'hABCD; ckp_a = ~v.ckp; cph_a = ~v.cph;
      end
      if (cyc == inject_cyc + 1) begin
        start_a = 1'b0; tx_a = v.tx; ckp_a = v.ckp; cph_a = v.cph;
      end
      if (rxv_a === 1'b1) begin
        lat = cyc;
        break;
      end
      if (cs_a !== v.exp_cs) cs_ok = 1'b0;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
      if (prev_sck == v.ckp && sck_a != v.ckp) begin
        lead++;
        seen_lead = 1'b1;
        if (!v.cph) mosi_w = {mosi_w[14:0], mosi_a};
      end
      if (prev_sck != v.ckp && sck_a == v.ckp && v.cph) mosi_w = {mosi_w[14:0], mosi_a};
      if (v.cph && !seen_lead && mosi_a !== 1'b0) pre_ok = 1'b0;
      prev_sck = sck_a;
      @(negedge clk);
      cyc++;
    end
    check("latency", lat, 32'd137);
    check("rx_data", {16'd0, rx_a}, {16'd0, v.exp_rx});
    check("lead_edges", lead, 32'd16);
    check("mosi_word", {16'd0, mosi_w}, {16'd0, v.tx});
    check("cs_during", {31'd0, cs_ok}, 32'd1);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("cph1_mosi_low_before_lead", {31'd0, pre_ok}, 32'd1);
    check("end_busy", {31'd0, busy_a}, 32'd0);
    check("end_cs", {29'd0, cs_a}, 32'h7);
    check("end_sck", {31'd0, sck_a}, {31'd0, v.ckp});
    @(negedge clk);
    check("rx_valid_pulse", {31'd0, rxv_a}, 32'd0);
    check("rx_data_stable", {16'd0, rx_a}, {16'd0, v.exp_rx});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, lead;
    logic prev;
    vec_t v;

    vecs[0] = '{ckp:1'b0, cph:1'b0, tx:16'h0509, loop:1'b1, miso_lvl:1'b0, sel:2'd0, exp_rx:16'h0509, exp_cs:3'b110};
    vecs[1] = '{ckp:1'b1, cph:1'b1, tx:16'hA5A5, loop:1'b0, miso_lvl:1'b1, sel:2'd1, exp_rx:16'hFFFF, exp_cs:3'b101};
    vecs[2] = '{ckp:1'b0, cph:1'b1, tx:16'h3C96, loop:1'b0, miso_lvl:1'b0, sel:2'd2, exp_rx:16'h0000, exp_cs:3'b011};
    vecs[3] = '{ckp:1'b1, cph:1'b0, tx:16'h8001, loop:1'b1, miso_lvl:1'b0, sel:2'd3, exp_rx:16'h8001, exp_cs:3'b111};
    vecs[4] = '{ckp:1'b1, cph:1'b1, tx:16'h6E3B, loop:1'b1, miso_lvl:1'b0, sel:2'd0, exp_rx:16'h6E3B, exp_cs:3'b110};

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_a", {29'd0, cs_a}, 32'h7);
    check("rst_mosi_a", {31'd0, mosi_a}, 32'd0);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_rxv_a", {31'd0, rxv_a}, 32'd0);
    check("rst_rx_a", {16'd0, rx_a}, 32'd0);
    check("rst_sck_a", {31'd0, sck_a}, 32'd0);
    check("rst_cs_b", {31'd0, cs_b}, 32'd1);
    check("rst_rx_b", {24'd0, rx_b}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i], -10);
    end

    // start pulsed mid-SHIFT with a new word and flipped mode pins: ignored
    v = '{ckp:1'b0, cph:1'b0, tx:16'h1234, loop:1'b1, miso_lvl:1'b0, sel:2'd1, exp_rx:16'h1234, exp_cs:3'b101};
    run_a(v, 50);

    // reset while bit 7 is being shifted
    @(negedge clk);
    tx_a = 16'hC3C3; sel_a = 2'd0; ckp_a = 1'b0; cph_a = 1'b0; loop_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lead = 0; cyc = 0; prev = 1'b0;
    while (lead < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (prev == 1'b0 && sck_a == 1'b1) lead++;
      prev = sck_a;
    end
    check("reached_bit7", lead, 32'd8);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs", {29'd0, cs_a}, 32'h7);
    check("midrst_mosi", {31'd0, mosi_a}, 32'd0);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v = '{ckp:1'b0, cph:1'b0, tx:16'h0F0F, loop:1'b1, miso_lvl:1'b0, sel:2'd2, exp_rx:16'h0F0F, exp_cs:3'b011};
    run_a(v, -10);

    // LSB-first 8-bit at HALF_DIV=1, then back-to-back start on the rx_valid cycle
    @(negedge clk);
    tx_b = 8'h01; ckp_b = 1'b0; cph_b = 1'b0; sel_b = 1'b0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_first_mosi", {31'd0, mosi_b}, 32'd1);
    check("b_cs_low", {31'd0, cs_b}, 32'd0);
    cyc = 1; lead = 0; prev = 1'b0;
    while (rxv_b !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (prev == 1'b0 && sck_b == 1'b1) lead++;
      prev = sck_b;
    end
    check("b_latency", cyc, 32'd19);
    check("b_rx", {24'd0, rx_b}, 32'h01);
    check("b_lead_edges", lead, 32'd8);
    check("b_end_busy", {31'd0, busy_b}, 32'd0);
    tx_b = 8'h96; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b2b_accepted", {31'd0, busy_b}, 32'd1);
    check("b2b_rxv_low", {31'd0, rxv_b}, 32'd0);
    cyc = 1;
    while (rxv_b !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", cyc, 32'd19);
    check("b2b_rx", {24'd0, rx_b}, 32'h96);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
